serialisering: RTL and testbench

Result serializer for the 4-lane parallel arithmetic unit. It captures one complete result frame, the twelve 8-bit lane results g1–g4, h1–h4 and i1–i4, in a single handshake. It then streams the frame out one word per beat over a valid/ready interface, so a narrow downstream consumer (UART bridge, logger, comparison bench) can drain the parallel results without its own 96-bit wide path.

---
 rtl/serialisering.sv | 137 +++++++++++++
 tb/tb_serialisering.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serialisering.sv
// Result serializer: captures a 12-lane result frame in one handshake and streams it out word by word.
// Optional build macro SERIALISERING_CHECKSUM_EN appends an XOR checksum word at index 12.
module serialisering #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] g1,
   input  logic [WIDTH-1:0] g2,
   input  logic [WIDTH-1:0] g3,
   input  logic [WIDTH-1:0] g4,
   input  logic [WIDTH-1:0] h1,
   input  logic [WIDTH-1:0] h2,
   input  logic [WIDTH-1:0] h3,
   input  logic [WIDTH-1:0] h4,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned LANES  = 12;
   localparam int unsigned IDX_W  = 4;
`ifdef SERIALISERING_CHECKSUM_EN
   localparam int unsigned NWORDS = LANES + 1;
`else
   localparam int unsigned NWORDS = LANES;
`endif
   localparam int unsigned LAST   = NWORDS - 1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_nxt;
   logic [WIDTH-1:0]     frame_buf [NWORDS];
   logic [WIDTH-1:0]     cap       [LANES];
   logic [WIDTH-1:0]     data_q;
   logic                 last_q;

   // Lane ports gathered in frame order.
   always_comb begin
      cap[0]  = g1;
      cap[1]  = g2;
      cap[2]  = g3;
      cap[3]  = g4;
      cap[4]  = h1;
      cap[5]  = h2;
      cap[6]  = h3;
      cap[7]  = h4;
      cap[8]  = i1;
      cap[9]  = i2;
      cap[10] = i3;
      cap[11] = i4;
   end

`ifdef SERIALISERING_CHECKSUM_EN
   logic [WIDTH-1:0] csum;

   always_comb begin
      csum = '0;
      for (int k = 0; k < LANES; k++) begin
         csum = csum ^ cap[k];
      end
   end
`endif

   always_comb begin
      idx_nxt = idx + IDX_W'(1);
   end

   // Frame FSM; out_data/out_last are preloaded one word ahead so they stay registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         data_q <= '0;
         last_q <= 1'b0;
         for (int k = 0; k < NWORDS; k++) begin
            frame_buf[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int k = 0; k < LANES; k++) begin
                     frame_buf[k] <= cap[k];
                  end
`ifdef SERIALISERING_CHECKSUM_EN
                  frame_buf[LANES] <= csum;
`endif
                  state  <= SEND;
                  idx    <= '0;
                  data_q <= cap[0];
                  last_q <= 1'b0;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (idx == IDX_W'(LAST)) begin
                     state  <= IDLE;
                     idx    <= '0;
                     data_q <= '0;
                     last_q <= 1'b0;
                  end else begin
                     idx    <= idx_nxt;
                     data_q <= frame_buf[idx_nxt];
                     last_q <= (idx_nxt == IDX_W'(LAST));
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign out_data  = data_q;
   assign out_index = idx;
   assign out_last  = last_q;

endmodule

// File: tb/tb_serialisering.sv
// Directed bench for serialisering: basic frame, stall, input isolation, back-to-back, reset behaviour.
module tb_serialisering;

   localparam int unsigned W = 8;
`ifdef SERIALISERING_CHECKSUM_EN
   localparam int NW = 13;
`else
   localparam int NW = 12;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] g1, g2, g3, g4, h1, h2, h3, h4, i1, i2, i3, i4;
   logic [W-1:0] out_data;
   logic [3:0]   out_index;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         busy;

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc   = 0;
   int           t0, t1;
   logic [W-1:0] cur [13];

   localparam logic [95:0] FRAME_A  = 96'h02_08_12_20_05_09_0D_11_FF_FF_FF_FF;
   localparam logic [95:0] FRAME_AA = {12{8'hAA}};
   localparam logic [95:0] FRAME_B  = 96'h01_02_03_04_05_06_07_08_09_0A_0B_0C;

   serialisering #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .g1(g1), .g2(g2), .g3(g3), .g4(g4),
      .h1(h1), .h2(h2), .h3(h3), .h4(h4),
      .i1(i1), .i2(i2), .i3(i3), .i4(i4),
      .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_inputs(input logic [95:0] f);
      {g1, g2, g3, g4, h1, h2, h3, h4, i1, i2, i3, i4} = f;
   endtask

   // Expected words, with the checksum modelled as the XOR of the twelve lanes.
   task automatic load_expect(input logic [95:0] f);
      logic [W-1:0] x;
      x = '0;
      for (int k = 0; k < 12; k++) begin
         cur[k] = f[95 - 8*k -: 8];
         x      = x ^ cur[k];
      end
      cur[12] = x;
   endtask

   task automatic drain(input string name, input int hold_at);
      for (int k = 0; k < NW; k++) begin
         if (k == hold_at) begin
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               check($sformatf("%s_hold%0d_data", name, j), 32'(out_data), 32'(cur[k]));
               check($sformatf("%s_hold%0d_index", name, j), 32'(out_index), 32'(k));
               check($sformatf("%s_hold%0d_valid", name, j), 32'(out_valid), 32'd1);
               step();
            end
            out_ready = 1'b1;
         end
         check($sformatf("%s_w%0d_valid", name, k), 32'(out_valid), 32'd1);
         check($sformatf("%s_w%0d_data", name, k), 32'(out_data), 32'(cur[k]));
         check($sformatf("%s_w%0d_index", name, k), 32'(out_index), 32'(k));
         check($sformatf("%s_w%0d_last", name, k), 32'(out_last), 32'(k == NW - 1));
         check($sformatf("%s_w%0d_in_ready", name, k), 32'(in_ready), 32'd0);
         check($sformatf("%s_w%0d_busy", name, k), 32'(busy), 32'd1);
         step();
      end
      check($sformatf("%s_idle_valid", name), 32'(out_valid), 32'd0);
      check($sformatf("%s_idle_in_ready", name), 32'(in_ready), 32'd1);
      check($sformatf("%s_idle_last", name), 32'(out_last), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive_inputs('0);
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Basic frame with out_ready held high.
      drive_inputs(FRAME_A);
      load_expect(FRAME_A);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drain("basic", -1);

      // Backpressure while index 4 is presented.
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drain("stall", 4);

      // Input changes and a pending in_valid during SEND must not disturb the frame.
      in_valid = 1'b1;
      step();
      drive_inputs(FRAME_AA);
      drain("isolate", -1);
      step();
      in_valid = 1'b0;
      load_expect(FRAME_AA);
      drain("isolate_aa", -1);

      // Back-to-back frames: first words are one frame period apart.
      drive_inputs(FRAME_A);
      load_expect(FRAME_A);
      in_valid = 1'b1;
      step();
      t0 = cyc;
      drive_inputs(FRAME_B);
      drain("b2b_first", -1);
      step();
      t1 = cyc;
      in_valid = 1'b0;
      check("b2b_spacing", 32'(t1 - t0), 32'(NW + 1));
      load_expect(FRAME_B);
      drain("b2b_second", -1);

      // Asynchronous reset in the middle of a frame.
      drive_inputs(FRAME_A);
      load_expect(FRAME_A);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("midrst_pre_index", 32'(out_index), 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_index", 32'(out_index), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("postrst%0d_out_valid", k), 32'(out_valid), 32'd0);
         check($sformatf("postrst%0d_in_ready", k), 32'(in_ready), 32'd1);
      end

      // Capture on the first clock after reset release.
      @(negedge clk);
      rst_n = 1'b0;
      drive_inputs(FRAME_B);
      load_expect(FRAME_B);
      in_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      in_valid = 1'b0;
      drain("rel_capture", -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
